stage_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, the instruction memory and the IF/ID pipeline register.
- Consumes the hazard controls (PC enable, IF/ID enable, IF flush) and the branch/jump redirect targets.
- Produces the instruction and PC+4 presented to DECODE.
- The instruction memory is loaded by the debug unit before execution. The stage stops fetching after latching a HALT instruction.

---
 rtl/stage_fetch.sv | 130 +++++++++++++
 tb/tb_stage_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: PC register, combinational-read instruction memory
// and the IF/ID pipeline register, with stall, flush, redirect and HALT handling.
module stage_fetch #(
  parameter int                 NB_DATA    = 32,
  parameter int                 NB_ADDR    = 8,
  parameter logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [NB_DATA-1:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_enable_pc,
  input  logic               i_enable_IF_ID_reg,
  input  logic               i_flush_IF,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_imem_wr_en,
  input  logic [NB_ADDR-1:0] i_imem_wr_addr,
  input  logic [NB_DATA-1:0] i_imem_wr_data,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_IF_ID_instruction,
  output logic [NB_DATA-1:0] o_IF_ID_pc_plus4,
  output logic               o_IF_ID_valid,
  output logic               o_halted
);

  localparam int                 DEPTH   = 2 ** NB_ADDR;
  localparam logic [NB_DATA-1:0] PC_STEP = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] ZERO    = {NB_DATA{1'b0}};

  logic [NB_DATA-1:0] imem [DEPTH];

  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] pc_plus4;
  logic               halt_load;

  // Read uses the pre-edge contents, so a same-cycle write is seen one cycle later.
  assign fetch_word = imem[pc_q[NB_ADDR+1:2]];
  assign pc_plus4   = pc_q + PC_STEP;
  assign halt_load  = ~i_flush_IF & ~halted_q & i_enable_IF_ID_reg & (fetch_word == HALT_INSTR);

  // Debug-loader write port, independent of reset and run enable
  always_ff @(posedge clk) begin
    if (i_imem_wr_en) begin
      imem[i_imem_wr_addr] <= i_imem_wr_data;
    end
  end

  // PC and halt-flag next state
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (i_reset) begin
      pc_d     = ZERO;
      halted_d = 1'b0;
    end else if (!i_enable) begin
      pc_d     = pc_q;
      halted_d = halted_q;
    end else if (i_branch_taken) begin
      pc_d     = i_branch_addr;
      halted_d = 1'b0;
    end else if (i_jump) begin
      pc_d     = i_jump_addr;
      halted_d = 1'b0;
    end else if (halted_q || !i_enable_pc || halt_load) begin
      // Latching HALT freezes the PC on the same edge
      pc_d     = pc_q;
      halted_d = halted_q | halt_load;
    end else begin
      pc_d     = pc_plus4;
      halted_d = halted_q;
    end
  end

  // IF/ID register next state
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (i_reset) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = ZERO;
      valid_d    = 1'b0;
    end else if (!i_enable) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (i_flush_IF) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b0;
    end else if (halted_q) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = pc_plus4_q;
      valid_d    = 1'b0;
    end else if (!i_enable_IF_ID_reg) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else begin
      instr_d    = fetch_word;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    instr_q    <= instr_d;
    pc_plus4_q <= pc_plus4_d;
    valid_q    <= valid_d;
    halted_q   <= halted_d;
  end

  assign o_pc                = pc_q;
  assign o_IF_ID_instruction = instr_q;
  assign o_IF_ID_pc_plus4    = pc_plus4_q;
  assign o_IF_ID_valid       = valid_q;
  assign o_halted            = halted_q;

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_stage_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_enable_pc = 1'b0;
  logic        i_enable_IF_ID_reg = 1'b0;
  logic        i_flush_IF = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_addr = 32'h0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_addr = 32'h0;
  logic        i_imem_wr_en = 1'b0;
  logic [7:0]  i_imem_wr_addr = 8'h0;
  logic [31:0] i_imem_wr_data = 32'h0;
  logic [31:0] o_pc;
  logic [31:0] o_IF_ID_instruction;
  logic [31:0] o_IF_ID_pc_plus4;
  logic        o_IF_ID_valid;
  logic        o_halted;

  stage_fetch dut (
    .clk                (clk),
    .i_reset            (i_reset),
    .i_enable           (i_enable),
    .i_enable_pc        (i_enable_pc),
    .i_enable_IF_ID_reg (i_enable_IF_ID_reg),
    .i_flush_IF         (i_flush_IF),
    .i_branch_taken     (i_branch_taken),
    .i_branch_addr      (i_branch_addr),
    .i_jump             (i_jump),
    .i_jump_addr        (i_jump_addr),
    .i_imem_wr_en       (i_imem_wr_en),
    .i_imem_wr_addr     (i_imem_wr_addr),
    .i_imem_wr_data     (i_imem_wr_data),
    .o_pc               (o_pc),
    .o_IF_ID_instruction(o_IF_ID_instruction),
    .o_IF_ID_pc_plus4   (o_IF_ID_pc_plus4),
    .o_IF_ID_valid      (o_IF_ID_valid),
    .o_halted           (o_halted)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from the rules, advance, compare all outputs.
  task automatic cycle();
    logic [31:0] word, n_pc, n_instr, n_pp4;
    logic        n_valid, n_halted, stop_here;
    word = m_mem[m_pc[9:2]];
    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid; n_halted = m_halted;
    if (i_reset) begin
      n_pc = 0; n_instr = NOP; n_pp4 = 0; n_valid = 0; n_halted = 0;
    end else if (i_enable) begin
      stop_here = !i_flush_IF && !m_halted && i_enable_IF_ID_reg && (word == HALT);
      if (i_flush_IF) begin
        n_instr = NOP; n_valid = 0; n_pp4 = m_pc + 32'd4;
      end else if (m_halted) begin
        n_instr = NOP; n_valid = 0;
      end else if (i_enable_IF_ID_reg) begin
        n_instr = word; n_valid = 1; n_pp4 = m_pc + 32'd4;
      end
      if (i_branch_taken) begin
        n_pc = i_branch_addr; n_halted = 0;
      end else if (i_jump) begin
        n_pc = i_jump_addr; n_halted = 0;
      end else begin
        if (!m_halted && i_enable_pc && !stop_here) n_pc = m_pc + 32'd4;
        if (stop_here) n_halted = 1;
      end
    end
    if (i_imem_wr_en) m_mem[i_imem_wr_addr] = i_imem_wr_data;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid; m_halted = n_halted;
    check("pc", o_pc, m_pc);
    check("instr", o_IF_ID_instruction, m_instr);
    check("pc_plus4", o_IF_ID_pc_plus4, m_pp4);
    check("valid", {31'd0, o_IF_ID_valid}, {31'd0, m_valid});
    check("halted", {31'd0, o_halted}, {31'd0, m_halted});
  endtask

  task automatic idle_controls();
    i_enable = 1; i_enable_pc = 1; i_enable_IF_ID_reg = 1; i_flush_IF = 0;
    i_branch_taken = 0; i_jump = 0; i_imem_wr_en = 0; i_reset = 0;
  endtask

  initial begin
    logic [31:0] w;
    m_pc = 0; m_instr = NOP; m_pp4 = 0; m_valid = 0; m_halted = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;

    // Load memory while held in reset
    i_reset = 1; i_imem_wr_en = 1;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h1234_5678;
      case (i)
        0: w = 32'h2001_0001;
        1: w = 32'h2002_0002;
        2: w = 32'h2003_0003;
        3: w = 32'h2004_0004;
        16: w = 32'h2005_0010;
        default: ;
      endcase
      i_imem_wr_addr = i[7:0]; i_imem_wr_data = w;
      cycle();
    end
    i_imem_wr_en = 0;
    cycle();
    check("rst_pc", o_pc, 32'h0);
    check("rst_valid", {31'd0, o_IF_ID_valid}, 32'h0);
    check("rst_instr", o_IF_ID_instruction, NOP);

    // Sequential fetch
    idle_controls();
    cycle();
    check("seq_pc4", o_pc, 32'h4);
    check("seq_i0", o_IF_ID_instruction, 32'h2001_0001);
    cycle();
    check("seq_i1", o_IF_ID_instruction, 32'h2002_0002);
    check("seq_pp4", o_IF_ID_pc_plus4, 32'h8);

    // Load-use stall at pc=8
    i_enable_pc = 0; i_enable_IF_ID_reg = 0;
    cycle();
    check("stall_pc", o_pc, 32'h8);
    check("stall_i", o_IF_ID_instruction, 32'h2002_0002);
    idle_controls();
    cycle();
    check("post_stall_i", o_IF_ID_instruction, 32'h2003_0003);
    check("post_stall_pc", o_pc, 32'hC);

    // Branch with flush at pc=12
    i_branch_taken = 1; i_branch_addr = 32'h40; i_flush_IF = 1;
    cycle();
    check("br_pc", o_pc, 32'h40);
    check("br_bubble", {31'd0, o_IF_ID_valid}, 32'h0);
    idle_controls();
    cycle();
    check("br_target", o_IF_ID_instruction, 32'h2005_0010);
    check("br_pp4", o_IF_ID_pc_plus4, 32'h44);

    // Branch beats jump; plant HALT at word 2 in the same cycle
    i_branch_taken = 1; i_branch_addr = 32'h10; i_jump = 1; i_jump_addr = 32'h80;
    i_imem_wr_en = 1; i_imem_wr_addr = 8'd2; i_imem_wr_data = HALT;
    cycle();
    check("br_wins", o_pc, 32'h10);

    // HALT at word 2
    idle_controls();
    i_jump = 1; i_jump_addr = 32'h0; i_flush_IF = 1;
    cycle();
    idle_controls();
    cycle();
    cycle();
    cycle();
    check("halt_instr", o_IF_ID_instruction, HALT);
    check("halt_flag", {31'd0, o_halted}, 32'h1);
    check("halt_pc", o_pc, 32'h8);
    cycle();
    check("halt_bubble", {31'd0, o_IF_ID_valid}, 32'h0);
    cycle();
    check("halt_pc_hold", o_pc, 32'h8);
    i_jump = 1; i_jump_addr = 32'h0;
    cycle();
    check("restart_flag", {31'd0, o_halted}, 32'h0);
    idle_controls();
    cycle();
    check("restart_i", o_IF_ID_instruction, 32'h2001_0001);

    // Freeze for 3 cycles with a concurrent write to word 5
    i_enable = 0; i_jump = 1; i_jump_addr = 32'h100; i_flush_IF = 1;
    i_imem_wr_en = 1; i_imem_wr_addr = 8'd5; i_imem_wr_data = 32'hCAFE_0005;
    cycle();
    i_imem_wr_en = 0;
    cycle();
    cycle();
    check("freeze_pc", o_pc, 32'h4);
    idle_controls();
    i_jump = 1; i_jump_addr = 32'h14;
    cycle();
    idle_controls();
    cycle();
    check("write_landed", o_IF_ID_instruction, 32'hCAFE_0005);

    // Reset pulse mid-run, memory retained
    i_reset = 1;
    cycle();
    check("rst2_pc", o_pc, 32'h0);
    idle_controls();
    cycle();
    check("rst2_mem", o_IF_ID_instruction, 32'h2001_0001);

    // PC wraps past 2^32
    i_jump = 1; i_jump_addr = 32'hFFFF_FFFC;
    cycle();
    idle_controls();
    cycle();
    check("wrap_pc", o_pc, 32'h0);
    check("wrap_i", o_IF_ID_instruction, m_mem[255]);

    // Randomized run
    for (int k = 0; k < 1500; k++) begin
      i_reset            = ($urandom_range(0, 99) < 2);
      i_enable           = ($urandom_range(0, 99) < 90);
      i_enable_pc        = ($urandom_range(0, 99) < 85);
      i_enable_IF_ID_reg = ($urandom_range(0, 99) < 85);
      i_flush_IF         = ($urandom_range(0, 99) < 10);
      i_branch_taken     = ($urandom_range(0, 99) < 6);
      i_jump             = ($urandom_range(0, 99) < 6);
      i_branch_addr      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)) << 2;
      i_jump_addr        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)) << 2;
      i_imem_wr_en       = ($urandom_range(0, 99) < 15);
      i_imem_wr_addr     = 8'($urandom_range(0, 255));
      i_imem_wr_data     = ($urandom_range(0, 99) < 20) ? HALT : $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
